ret_addr_stack: RTL
===================

# ret_addr_stack

Parametrised return-address stack for the branch-prediction front end: the successor to the fixed 16-entry return predictor. It pushes the link address on predicted calls and supplies the predicted target on returns. On a mispredict it restores its state from a checkpoint. Depth and address width are parameters. It adds simultaneous push/pop, circular overflow and flagged underflow. It sits beside the branch predictor in IF, and checkpoints travel down the pipe with each predicted branch.

## Interface
- `XLEN`, 32, address width
- `DEPTH`, 16, number of entries; power of two, ≥ 2
- `PTR_W`, `$clog2(DEPTH)`, pointer width; derived, do not override
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  **synchronous, active-high** reset
- `push_i`  in  1  predicted call: push `push_addr_i`
- `push_addr_i`  in  XLEN  return address to push (call PC + 4)
- `pop_i`  in  1  predicted return: consume the top entry
- `restore_i`  in  1  mispredict recovery: load pointer and count from the restore inputs
- `restore_ptr_i`  in  PTR_W  checkpointed write pointer
- `restore_cnt_i`  in  PTR_W+1  checkpointed occupancy
- `top_valid_o`  out  1  stack not empty
- `top_addr_o`  out  XLEN  predicted return target; 0 when empty
- `ckpt_ptr_o`  out  PTR_W  current write pointer, to be captured with the branch
- `ckpt_cnt_o`  out  PTR_W+1  current occupancy
- `full_o`, `empty_o`  out  1  occupancy status
- `overflow_o`  out  1  push discarded the oldest entry this cycle
- `underflow_o`  out  1  pop requested while empty this cycle

## Operation
- State:
  - `mem[DEPTH]`
  - `ptr`: next write index
  - `cnt`: occupancy, 0..DEPTH
- Top entry is `mem[ptr-1]`, with the index taken modulo DEPTH (wraps naturally at PTR_W bits).
- Requests in one cycle are resolved in this priority order:
  1. `restore_i`: `ptr <= restore_ptr_i`, `cnt <= restore_cnt_i`. `push_i` and `pop_i` are ignored and no flag is raised. `mem` is unchanged unless `RAS_TOP_REPAIR_EN` is defined.
  2. `push_i & pop_i` (return-then-call):
     - `cnt > 0`: overwrite `mem[ptr-1]` with `push_addr_i`; `ptr` and `cnt` are unchanged.
     - `cnt == 0`: behaves as a plain push.
  3. `push_i` only:
     - `mem[ptr] <= push_addr_i`, `ptr <= ptr+1`.
     - If `cnt < DEPTH`, then `cnt <= cnt+1`.
     - Otherwise `cnt` stays at DEPTH and `overflow_o = 1`; the oldest entry is overwritten (circular buffer).
  4. `pop_i` only:
     - `cnt > 0`: `ptr <= ptr-1`, `cnt <= cnt-1`.
     - `cnt == 0`: no state change, `underflow_o = 1`.
- Flags:
  - `full_o = (cnt == DEPTH)`
  - `empty_o = (cnt == 0)`
  - `top_valid_o = ~empty_o`
- Restore is trusted: `restore_cnt_i > DEPTH` is illegal input and the bench asserts against it.

## Timing
- Reset values:
  - `ptr = 0`, `cnt = 0`
  - `top_valid_o = 0`, `top_addr_o = 0`
  - `empty_o = 1`, `full_o = 0`
  - `overflow_o = 0`, `underflow_o = 0`
  - `ckpt_ptr_o = 0`, `ckpt_cnt_o = 0`
  - `mem` is not cleared.
- Reset wins over all requests in the same cycle. Reset during any sequence fully empties the stack on that edge.
- `top_addr_o`, `top_valid_o`, `ckpt_*`, `full_o` and `empty_o` are combinational from registered state only. There is no combinational path from `push_*`, `pop_i` or `restore_*` to them.
- A pop consumes the `top_addr_o` value presented in the same cycle. The new top is visible one cycle later.
- A push becomes visible on `top_addr_o` one cycle after the request. There is no write-through bypass.
- `overflow_o` and `underflow_o` are combinational from the request plus state, valid in the request cycle only.
- Checkpoint values sampled in cycle N describe state before that cycle's push/pop.

## Configuration
- `RAS_TOP_REPAIR_EN` defined:
  - Adds port `ckpt_top_o` (out, XLEN) = `mem[ptr-1]`.
  - Adds port `restore_top_i` (in, XLEN).
  - On `restore_i`, also writes `mem[restore_ptr_i-1] <= restore_top_i` when `restore_cnt_i > 0`. This repairs a top entry corrupted by a wrong-path push.
- Macro undefined: those ports are absent and restore touches pointer and count only.

## Test plan
- Reset, then push 0x100, 0x200, 0x300 on consecutive cycles -> `top_addr_o` = 0x300, `cnt` = 3. Then three pops -> tops 0x300, 0x200, 0x100 consumed in order, then `empty_o = 1`, `top_addr_o = 0`.
- DEPTH = 16: push 17 addresses 0x1000..0x1040 (step 4) -> `overflow_o` = 1 only on the 17th push, `full_o = 1`. 16 pops then return 0x1040 down to 0x1004; a 17th pop gives `underflow_o = 1` with state unchanged.
- Stack holds [0xA0, 0xB0]; assert `push_i & pop_i` with 0xC0 -> next-cycle top = 0xC0, `cnt` = 2. Pop -> top = 0xA0.
- Capture `ckpt_*` with stack [0x10, 0x20]; push 0x30 and pop twice (wrong path); `restore_i` -> top = 0x20, `cnt` = 2. With `RAS_TOP_REPAIR_EN`: wrong-path pop then push of 0x99 overwrites 0x20; restore with `restore_top_i` = 0x20 -> top = 0x20.
- `restore_i` with `push_i` and `pop_i` also asserted -> restore applied, no flag raised. `reset` together with `push_i` -> stack empty after the edge.

Source files
------------

// File: rtl/ret_addr_stack_if.sv
// Bus between the branch-prediction front end and the return-address stack.
// Request side: push_i/push_addr_i (call), pop_i (return), restore_i with the
// checkpointed pointer/count. Response side: top entry, checkpoint values,
// occupancy status and per-cycle overflow/underflow flags.
// Optional macro RAS_TOP_REPAIR_EN adds ckpt_top_o and restore_top_i.
// master: the predictor driving requests; slave: the stack itself.
interface ret_addr_stack_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic             push_i;
  logic [XLEN-1:0]  push_addr_i;
  logic             pop_i;
  logic             restore_i;
  logic [PTR_W-1:0] restore_ptr_i;
  logic [PTR_W:0]   restore_cnt_i;
  logic             top_valid_o;
  logic [XLEN-1:0]  top_addr_o;
  logic [PTR_W-1:0] ckpt_ptr_o;
  logic [PTR_W:0]   ckpt_cnt_o;
  logic             full_o;
  logic             empty_o;
  logic             overflow_o;
  logic             underflow_o;
`ifdef RAS_TOP_REPAIR_EN
  logic [XLEN-1:0]  ckpt_top_o;
  logic [XLEN-1:0]  restore_top_i;

  modport master (
    output push_i, push_addr_i, pop_i, restore_i, restore_ptr_i, restore_cnt_i, restore_top_i,
    input  top_valid_o, top_addr_o, ckpt_ptr_o, ckpt_cnt_o, full_o, empty_o, overflow_o,
           underflow_o, ckpt_top_o
  );
  modport slave (
    input  push_i, push_addr_i, pop_i, restore_i, restore_ptr_i, restore_cnt_i, restore_top_i,
    output top_valid_o, top_addr_o, ckpt_ptr_o, ckpt_cnt_o, full_o, empty_o, overflow_o,
           underflow_o, ckpt_top_o
  );
`else
  modport master (
    output push_i, push_addr_i, pop_i, restore_i, restore_ptr_i, restore_cnt_i,
    input  top_valid_o, top_addr_o, ckpt_ptr_o, ckpt_cnt_o, full_o, empty_o, overflow_o,
           underflow_o
  );
  modport slave (
    input  push_i, push_addr_i, pop_i, restore_i, restore_ptr_i, restore_cnt_i,
    output top_valid_o, top_addr_o, ckpt_ptr_o, ckpt_cnt_o, full_o, empty_o, overflow_o,
           underflow_o
  );
`endif
endinterface

// File: rtl/ret_addr_stack.sv
// Return-address stack for the IF-stage branch predictor.
// Pushes link addresses on predicted calls, supplies the predicted target on
// returns, and restores pointer/count from a checkpoint on mispredict.
// Circular on overflow (oldest entry is overwritten), flags pops on empty.
// Ports:
//   clk   - clock, all state updates on the rising edge
//   reset - synchronous active-high reset (empties the stack)
//   bus   - ret_addr_stack_if.slave: requests in, top/checkpoint/status out
// Optional macro RAS_TOP_REPAIR_EN: exports the top entry as ckpt_top_o and
// rewrites it from restore_top_i on restore.
module ret_addr_stack #(
  parameter  int unsigned XLEN  = 32,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  ret_addr_stack_if.slave   bus
);

  localparam logic [PTR_W:0] FullCnt = (PTR_W+1)'(DEPTH);

  logic [XLEN-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0] top_idx;
  logic             empty;

  logic             mem_we;
  logic [PTR_W-1:0] mem_waddr;
  logic [XLEN-1:0]  mem_wdata;
  logic             overflow;
  logic             underflow;

  // Top sits just below the write pointer; wraps at PTR_W bits.
  assign top_idx = ptr_q - PTR_W'(1);
  assign empty   = (cnt_q == '0);

  always_comb begin
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = ptr_q;
    mem_wdata = bus.push_addr_i;
    overflow  = 1'b0;
    underflow = 1'b0;

    if (bus.restore_i) begin
      ptr_d = bus.restore_ptr_i;
      cnt_d = bus.restore_cnt_i;
`ifdef RAS_TOP_REPAIR_EN
      if (bus.restore_cnt_i != '0) begin
        mem_we    = 1'b1;
        mem_waddr = bus.restore_ptr_i - PTR_W'(1);
        mem_wdata = bus.restore_top_i;
      end
`endif
    end else if (bus.push_i && bus.pop_i && !empty) begin
      // Return-then-call: replace the top in place.
      mem_we    = 1'b1;
      mem_waddr = top_idx;
    end else if (bus.push_i) begin
      mem_we = 1'b1;
      ptr_d  = ptr_q + PTR_W'(1);
      if (cnt_q < FullCnt) begin
        cnt_d = cnt_q + (PTR_W+1)'(1);
      end else begin
        overflow = 1'b1;
      end
    end else if (bus.pop_i) begin
      if (!empty) begin
        ptr_d = ptr_q - PTR_W'(1);
        cnt_d = cnt_q - (PTR_W+1)'(1);
      end else begin
        underflow = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is never cleared; reset only suppresses the write.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.top_valid_o = !empty;
  assign bus.top_addr_o  = empty ? '0 : mem[top_idx];
  assign bus.ckpt_ptr_o  = ptr_q;
  assign bus.ckpt_cnt_o  = cnt_q;
  assign bus.full_o      = (cnt_q == FullCnt);
  assign bus.empty_o     = empty;
  // Flags are quiet while reset is asserted so state before the first reset is never exposed.
  assign bus.overflow_o  = overflow && !reset;
  assign bus.underflow_o = underflow && !reset;
`ifdef RAS_TOP_REPAIR_EN
  assign bus.ckpt_top_o  = mem[top_idx];
`endif

endmodule
